// File: rtl/axi_bram_slave.sv
// AXI4 slave terminating 32-bit bursts into an internal word RAM.
// Ports: axi_aclk/axi_areset (sync, high), s_axi_aw/w/b write channels,
// s_axi_ar/r read channels. With AXI_BRAM_SLAVE_STATS_EN defined it
// also drives wr_burst_cnt, rd_burst_cnt and err_cnt (saturating).
module axi_bram_slave #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int STRB_W    = 4,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  output logic              s_axi_awready,
  input  logic              s_axi_awvalid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [1:0]        s_axi_awburst,
  input  logic [3:0]        s_axi_awcache,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  output logic              s_axi_wready,
  input  logic              s_axi_wvalid,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0] s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_bready,
  output logic              s_axi_bvalid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_arready,
  input  logic              s_axi_arvalid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [1:0]        s_axi_arburst,
  input  logic [3:0]        s_axi_arcache,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic              s_axi_rready,
  output logic              s_axi_rvalid,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic              s_axi_rlast,
  output logic [1:0]        s_axi_rresp
`ifdef AXI_BRAM_SLAVE_STATS_EN
  ,
  output logic [31:0]       wr_burst_cnt,
  output logic [31:0]       rd_burst_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-3:0] DEPTH_L =
    (ADDR_W-2)'(MEM_DEPTH);

  localparam logic [1:0] BT_FIXED = 2'b00;
  localparam logic [1:0] BT_INCR  = 2'b01;
  localparam logic [1:0] BT_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE, R_DATA
  } r_state_e;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic wrap_ok(
    input logic [7:0] len
  );
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

  // DECERR wins over SLVERR.
  function automatic logic [1:0] burst_resp(
    input logic [ADDR_W-1:0] addr,
    input logic [1:0]        burst,
    input logic [7:0]        len,
    input logic [2:0]        size
  );
    logic dec;
    logic slv;
    dec = addr[ADDR_W-1:2] >= DEPTH_L;
    slv = (size != 3'b010) ||
          (burst == 2'b11) ||
          ((burst == BT_WRAP) && !wrap_ok(len));
    if (dec)      return 2'b11;
    else if (slv) return 2'b10;
    else          return 2'b00;
  endfunction

  // Reserved and illegal-length WRAP fall back to INCR.
  function automatic logic [1:0] eff_burst(
    input logic [1:0] burst,
    input logic [7:0] len
  );
    if (burst == BT_FIXED)
      return BT_FIXED;
    else if (burst == BT_WRAP && wrap_ok(len))
      return BT_WRAP;
    else
      return BT_INCR;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(
    input logic [IDX_W-1:0] idx,
    input logic [1:0]       burst,
    input logic [7:0]       len
  );
    logic [IDX_W-1:0] mask;
    logic [IDX_W-1:0] inc;
    mask = IDX_W'(len);
    inc  = idx + IDX_W'(1);
    unique case (burst)
      BT_FIXED: return idx;
      BT_WRAP:  return (idx & ~mask) | (inc & mask);
      default:  return inc;
    endcase
  endfunction

  // ---------------- write channel ----------------
  w_state_e         w_state_q, w_state_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [7:0]       wlen_q, wlen_d;
  logic [7:0]       wbeat_q, wbeat_d;
  logic [1:0]       wburst_q, wburst_d;
  logic [1:0]       wresp_q, wresp_d;
  logic             w_final;
  logic             mem_we;

  always_comb begin
    w_state_d = w_state_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    wburst_d  = wburst_q;
    wresp_d   = wresp_q;
    w_final   = (wbeat_q == wlen_q);
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid) begin
          widx_d   = s_axi_awaddr[IDX_W+1:2];
          wlen_d   = s_axi_awlen;
          wbeat_d  = 8'd0;
          wburst_d = eff_burst(s_axi_awburst,
                               s_axi_awlen);
          wresp_d  = burst_resp(s_axi_awaddr,
                                s_axi_awburst,
                                s_axi_awlen,
                                s_axi_awsize);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          mem_we  = (wresp_q != 2'b11) && !axi_areset;
          widx_d  = next_idx(widx_q, wburst_q, wlen_q);
          wbeat_d = wbeat_q + 8'd1;
          // Burst length, not wlast, ends the burst.
          if (s_axi_wlast != w_final && wresp_q == 2'b00)
            wresp_d = 2'b10;
          if (w_final)
            w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready)
          w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      w_state_q <= W_IDLE;
      widx_q    <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      wburst_q  <= BT_INCR;
      wresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      wburst_q  <= wburst_d;
      wresp_q   <= wresp_d;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b])
          mem[widx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi_awready = (w_state_q == W_IDLE);
  assign s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bresp   = s_axi_bvalid ? wresp_q : 2'b00;

  // ---------------- read channel ----------------
  r_state_e          r_state_q, r_state_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d;
  logic [7:0]        rlen_q, rlen_d;
  logic [7:0]        rbeat_q, rbeat_d;
  logic [1:0]        rburst_q, rburst_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic [DATA_W-1:0] rdata_q;
  logic              rd_en;
  logic              rd_zero;
  logic [IDX_W-1:0]  rd_idx;

  // ridx_q always holds the word for the next fetch.
  always_comb begin
    r_state_d = r_state_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    rburst_d  = rburst_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rd_en     = 1'b0;
    rd_zero   = (rresp_q == 2'b11);
    rd_idx    = ridx_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          rd_en    = 1'b1;
          rd_idx   = s_axi_araddr[IDX_W+1:2];
          rlen_d   = s_axi_arlen;
          rbeat_d  = 8'd0;
          rburst_d = eff_burst(s_axi_arburst,
                               s_axi_arlen);
          rresp_d  = burst_resp(s_axi_araddr,
                                s_axi_arburst,
                                s_axi_arlen,
                                s_axi_arsize);
          rd_zero  = (rresp_d == 2'b11);
          rlast_d  = (s_axi_arlen == 8'd0);
          ridx_d   = next_idx(rd_idx, rburst_d,
                              s_axi_arlen);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (rbeat_q == rlen_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            rd_en   = 1'b1;
            ridx_d  = next_idx(ridx_q, rburst_q, rlen_q);
            rbeat_d = rbeat_q + 8'd1;
            rlast_d = (rbeat_d == rlen_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_state_q <= R_IDLE;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rburst_q  <= BT_INCR;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rburst_q  <= rburst_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  // Registered RAM read port; a same-edge write is
  // seen only by later reads (read-first).
  always_ff @(posedge axi_aclk) begin
    if (axi_areset)
      rdata_q <= '0;
    else if (rd_en)
      rdata_q <= rd_zero ? '0 : mem[rd_idx];
  end

  assign s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = s_axi_rvalid ? rresp_q : 2'b00;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awcache, s_axi_arcache,
                       s_axi_awaddr[1:0],
                       s_axi_araddr[1:0]};

`ifdef AXI_BRAM_SLAVE_STATS_EN
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        b_hs, rl_hs;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  always_comb begin
    b_hs    = s_axi_bvalid & s_axi_bready;
    rl_hs   = s_axi_rvalid & s_axi_rready & rlast_q;
    err_inc = {1'b0, b_hs && (s_axi_bresp != 2'b00)} +
              {1'b0, rl_hs && (s_axi_rresp != 2'b00)};
    err_sum = {1'b0, err_cnt_q} + 17'(err_inc);
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_sum[16] ? '1 : err_sum[15:0];
    if (b_hs && wr_cnt_q != '1)
      wr_cnt_d = wr_cnt_q + 32'd1;
    if (rl_hs && rd_cnt_q != '1)
      rd_cnt_d = rd_cnt_q + 32'd1;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign wr_burst_cnt = wr_cnt_q;
  assign rd_burst_cnt = rd_cnt_q;
  assign err_cnt      = err_cnt_q;
`endif

endmodule

// File: doc/axi_bram_slave.md
Name: axi_bram_slave

Overview:
- AXI4 memory-mapped slave with internal word-addressed RAM.
- Sits directly downstream of the procvter AXI4 master. It terminates the s_axi_* bursts procvter issues, either directly or behind axi_wrapper.
- Write and read channels are independent FSMs sharing one RAM (one write port, one read port).
- Written data is returned on read so the generator can self-check.

Parameters:
ADDR_W, 32, address width of awaddr/araddr
DATA_W, 32, data width; fixed at 32 in this block
STRB_W, 4, byte-strobe width (DATA_W/8)
MEM_DEPTH, 1024, RAM depth in DATA_W words; power of two

Ports:
axi_aclk  in  1  single clock, all logic rising-edge
axi_areset  in  1  reset, synchronous, active-high
s_axi_awready  out  1  write-address ready
s_axi_awvalid  in  1  write-address valid
s_axi_awaddr  in  ADDR_W  byte start address (word-aligned)
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s_axi_awcache  in  4  accepted, ignored
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  must be 3'b010
s_axi_wready  out  1  write-data ready
s_axi_wvalid  in  1  write-data valid
s_axi_wdata  in  DATA_W  write data
s_axi_wstrb  in  STRB_W  byte enables
s_axi_wlast  in  1  last write beat
s_axi_bready  in  1  response ready
s_axi_bvalid  out  1  response valid
s_axi_bresp  out  2  write response
s_axi_arready / arvalid / araddr / arburst / arcache / arlen / arsize  (same widths and meaning as AW)
s_axi_rready  in  1  read-data ready
s_axi_rvalid  out  1  read-data valid
s_axi_rdata  out  DATA_W  read data
s_axi_rlast  out  1  last read beat
s_axi_rresp  out  2  read response

Behaviour:
- Reset (axi_areset=1 at a clock edge):
  - awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; bresp, rresp = 00; rdata = 0.
  - Both FSMs return to IDLE. An in-flight burst is abandoned; no B or R response is issued.
  - RAM contents are not cleared.
- Word index: addr[ADDR_W-1:2]. In range if the index is < MEM_DEPTH; otherwise the burst is DECERR.
- Burst address update per beat:
  - FIXED: hold.
  - INCR: +1.
  - WRAP: +1 within an aligned block of (awlen+1) words.
  - Reserved (11): behaves as INCR, response SLVERR.
- Error rules:
  - Size error: awsize/arsize != 010 gives SLVERR; writes still performed.
  - WRAP with len not in {1,3,7,15} gives SLVERR; treated as INCR.
  - DECERR (11) takes precedence over SLVERR (10).
  - DECERR suppresses every RAM write in that burst; reads return 0.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On awvalid&awready, latch address, len, burst and error; next cycle enter W_DATA with awready=0, wready=1.
  - W_DATA: each wvalid&wready beat writes the bytes whose wstrb bit is 1, then advances the address and beat counter.
  - Termination is by beat count (beat == len), not wlast.
  - A wlast mismatch (asserted early, or absent on the final beat) sets SLVERR.
  - After the final beat: wready=0, bvalid=1 next cycle (W_RESP).
  - W_RESP: hold bvalid and bresp until bready. On the handshake, bvalid=0 and awready=1 next cycle.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On the handshake, rdata <= RAM[start]; next cycle rvalid=1, arready=0, rlast=(len==0). AR-to-first-data latency is 1 cycle.
  - R_DATA: on rvalid&rready with beat != len, rdata <= RAM[next] and rvalid stays 1 (one beat per cycle under continuous rready).
  - rdata, rresp and rlast are stable while rvalid&!rready.
  - rresp is identical on every beat of a burst.
  - After the last beat: rvalid=0, rlast=0, arready=1 next cycle.
- Same-cycle write and read to the same word: read-first, i.e. rdata gets the old contents.
- 256-beat bursts (len=255) are supported; the beat counter is 8 bits and does not overflow.

Optional Feature:
- Macro AXI_BRAM_SLAVE_STATS_EN.
- Defined: adds three outputs, all cleared by axi_areset and saturating at max:
  - wr_burst_cnt[31:0]: +1 per B handshake.
  - rd_burst_cnt[31:0]: +1 per rlast handshake.
  - err_cnt[15:0]: +1 per B or last-R handshake with resp != 00.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- INCR write: awaddr=0x10, len=3, wdata 0xA0..0xA3, wstrb=F, then read the same burst -> bresp=00; rdata A0,A1,A2,A3, rlast on the 4th beat, rresp=00, first rvalid 1 cycle after AR handshake.
- Partial strobe: write 0xFFFFFFFF to 0x0, then 0x12345678 with wstrb=0101 -> read returns 0xFF34FF78.
- WRAP: awaddr=0x18, len=3 -> writes land at words 6,7,4,5; an FIXED read len=2 at 0x18 -> same word returned 3x.
- Error cases:
  - awaddr=MEM_DEPTH*4 -> bresp=11 and RAM unchanged.
  - arsize=001 -> rresp=10 on every beat.
  - wlast high on beat 1 of len=3 -> bresp=10, 4 beats accepted.
- Backpressure: rready toggling 1/0 and bready held low 5 cycles -> no beat lost or duplicated, outputs stable while stalled, bvalid held.
- Reset mid-burst: assert axi_areset during beat 2 of a len=7 write -> next cycle awready=1, wready=0, bvalid=0; a subsequent read of the written words shows beats 0-1 only.
